// File: rtl/lb_rtc_rgs.sv
// lb_rtc_rgs: localbus register bank for the 1588 RTC (load/adjust, capture, timestamp FIFO).
// Optional LB_RTC_RGS_OVF_CNT_EN adds a saturating dropped-timestamp counter at 0x3C.
module lb_rtc_rgs #(
  parameter int          TS_AW      = 3,
  parameter logic [31:0] RST_PERIOD = 32'h0800_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_in,
  input  logic        rd_in,
  input  logic [7:0]  addr_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rtc_time_ld,
  output logic        rtc_period_ld,
  output logic [47:0] rtc_time_sec,
  output logic [31:0] rtc_time_nsc,
  output logic [31:0] rtc_period,
  input  logic [47:0] rtc_sec_in,
  input  logic [31:0] rtc_nsc_in,
  input  logic        ts_valid,
  input  logic [31:0] ts_sec,
  input  logic [31:0] ts_nsc,
  input  logic [31:0] ts_info,
  output logic        ts_irq
);
  localparam int DEPTH = 1 << TS_AW;
  logic [5:0]       a;
  logic             unused_addr;
  logic [15:0]      sec_h_q;
  logic [31:0]      sec_l_q, nsc_q, per_q, cap_nsc_q, dout_q, rdata;
  logic [47:0]      cap_sec_q;
  logic [2:0]       pls_q;
  logic [TS_AW-1:0] wp_q, rp_q;
  logic [TS_AW:0]   lvl_q, lvl_d;
  logic             ovf_q, ovf_d, empty, full, pop, push, drop;
  logic [95:0]      mem [DEPTH];
  logic [95:0]      head;
  assign a           = addr_in[7:2];
  assign unused_addr = ^addr_in[1:0];
  assign empty       = lvl_q == '0;
  assign full        = lvl_q == (TS_AW+1)'(DEPTH);
  assign pop         = rd_in && a == 6'h0E && !empty;
  assign push        = ts_valid && (!full || pop);
  assign drop        = ts_valid && full && !pop;
  assign head        = empty ? 96'b0 : mem[rp_q];
  assign lvl_d       = lvl_q + (TS_AW+1)'(push) - (TS_AW+1)'(pop);
  // a W1C clear loses to an overflow event in the same cycle
  assign ovf_d       = drop | (ovf_q & ~(wr_in && a == 6'h01 && data_in[2]));
  assign data_out      = dout_q;
  assign rtc_time_ld   = pls_q[0];
  assign rtc_period_ld = pls_q[1];
  assign rtc_time_sec  = {sec_h_q, sec_l_q};
  assign rtc_time_nsc  = nsc_q;
  assign rtc_period    = per_q;
  assign ts_irq        = !empty;
`ifdef LB_RTC_RGS_OVF_CNT_EN
  logic [15:0] ocnt_q, ocnt_d;
  assign ocnt_d = (wr_in && a == 6'h0F) ? {15'b0, drop} : ocnt_q + 16'(drop && ocnt_q != 16'hFFFF);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ocnt_q <= '0;
    else ocnt_q <= ocnt_d;
`endif
  always_comb begin
    rdata = '0;
    case (a)
      6'h01: rdata = (32'(lvl_q) << 8) | {29'b0, ovf_q, full, empty};
      6'h04: rdata = {16'b0, sec_h_q};
      6'h05: rdata = sec_l_q;
      6'h06: rdata = nsc_q;
      6'h07: rdata = per_q;
      6'h08: rdata = {16'b0, cap_sec_q[47:32]};
      6'h09: rdata = cap_sec_q[31:0];
      6'h0A: rdata = cap_nsc_q;
      6'h0C: rdata = head[95:64];
      6'h0D: rdata = head[63:32];
      6'h0E: rdata = head[31:0];
`ifdef LB_RTC_RGS_OVF_CNT_EN
      6'h0F: rdata = {16'b0, ocnt_q};
`endif
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sec_h_q   <= '0;
      sec_l_q   <= '0;
      nsc_q     <= '0;
      per_q     <= RST_PERIOD;
      cap_sec_q <= '0;
      cap_nsc_q <= '0;
      pls_q     <= '0;
      dout_q    <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      lvl_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pls_q <= (wr_in && a == 6'h00) ? data_in[2:0] : 3'b0;
      if (wr_in && a == 6'h04) sec_h_q <= data_in[15:0];
      if (wr_in && a == 6'h05) sec_l_q <= data_in;
      if (wr_in && a == 6'h06) nsc_q <= data_in;
      if (wr_in && a == 6'h07) per_q <= data_in;
      if (pls_q[2]) begin
        cap_sec_q <= rtc_sec_in;
        cap_nsc_q <= rtc_nsc_in;
      end
      if (rd_in) dout_q <= rdata;
      if (pop) rp_q <= rp_q + 1'b1;
      if (push) wp_q <= wp_q + 1'b1;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
    end
  always_ff @(posedge clk)
    if (push) mem[wp_q] <= {ts_sec, ts_nsc, ts_info};
endmodule

// File: doc/lb_rtc_rgs.md
Name: lb_rtc_rgs

Overview:
- Localbus register bank for the 1588 RTC and timestamp unit; it sits directly downstream of the wishbone slave wrapper and consumes its wr/rd/addr/data strobes.
- Drives RTC load/adjust controls and snapshots live RTC time.
- Buffers hardware timestamps in an internal FIFO that software drains through registers.
- Read data is registered with 1-cycle latency, so it is valid on the wrapper's ack cycle.

Parameters:
TS_AW, 3, timestamp FIFO address width; depth = 2**TS_AW entries (8)
RST_PERIOD, 32'h0800_0000, reset value of PERIOD register (8.0 ns, 24-bit fraction)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
wr_in  in  1  1-cycle write strobe
rd_in  in  1  1-cycle read strobe
addr_in  in  8  byte address; bits[1:0] ignored
data_in  in  32  write data
data_out  out  32  registered read data
rtc_time_ld  out  1  1-cycle pulse: load rtc_time_sec/rtc_time_nsc
rtc_period_ld  out  1  1-cycle pulse: load rtc_period
rtc_time_sec  out  48  {TIME_SEC_H[15:0], TIME_SEC_L}
rtc_time_nsc  out  32  TIME_NSC value
rtc_period  out  32  PERIOD value
rtc_sec_in  in  48  live RTC seconds
rtc_nsc_in  in  32  live RTC nanoseconds
ts_valid  in  1  push strobe from timestamp unit
ts_sec  in  32  timestamp seconds (low 32)
ts_nsc  in  32  timestamp nanoseconds
ts_info  in  32  message id/seq info
ts_irq  out  1  level: FIFO non-empty

Behaviour:
- Register map (byte addr):
  - 0x00 CTRL (W): bit0 TIME_LD, bit1 PERIOD_LD, bit2 CAP. Write-1 produces a 1-cycle pulse the cycle after wr_in. Reads return 0.
  - 0x04 STATUS (R, W1C on bit2): bit0 empty, bit1 full, bit2 overflow (sticky), bits[11:8] level (0..8).
  - 0x10 TIME_SEC_H [15:0], 0x14 TIME_SEC_L, 0x18 TIME_NSC, 0x1C PERIOD: all RW.
  - 0x20 CAP_SEC_H, 0x24 CAP_SEC_L, 0x28 CAP_NSC: RO snapshot.
  - 0x30 TS_SEC, 0x34 TS_NSC, 0x38 TS_INFO: RO, FIFO head.
- Reset values:
  - data_out, all RW/RO regs, pulses, ts_irq, overflow: 0.
  - PERIOD: RST_PERIOD.
  - FIFO: empty, pointers 0.
- Address decode and access rules:
  - Unmapped writes are ignored; unmapped reads return 0.
  - Writes to RO addresses are ignored.
  - Unused upper bits read 0.
- Read timing: data_out updates on the clk edge after rd_in and holds until the next rd_in.
- CAP: on the pulse cycle, latch rtc_sec_in/rtc_nsc_in into the CAP regs atomically.
- TIME_LD and PERIOD_LD:
  - Output buses show current register values continuously.
  - The pulse asserts one cycle after the CTRL write, which is always after any earlier register write has settled.
  - Writes of both bits in one access pulse both outputs simultaneously.
- FIFO:
  - Width 96, depth 2**TS_AW.
  - Push on ts_valid if not full, or if full with a pop in the same cycle.
  - Pop on rd_in to 0x38 when not empty. data_out captures the head TS_INFO before the pop.
  - Reading 0x38 when empty returns 0, no pop, pointers unchanged.
  - Push while full without a pop: entry dropped, overflow set.
  - Simultaneous push and pop keeps level unchanged.
  - Pointers wrap modulo depth; level uses a TS_AW+1 bit counter.
- Overflow:
  - Cleared by writing 1 to STATUS bit2.
  - A concurrent overflow event in the same cycle wins, and the bit stays set.
- ts_irq = !empty, registered with the FIFO state.
- Reset mid-operation clears everything immediately (asynchronous). No pulse is emitted on reset release.

Optional Feature:
- Macro LB_RTC_RGS_OVF_CNT_EN.
- Defined: adds 0x3C OVF_CNT (R, clear-on-write any value), a 16-bit saturating count of dropped timestamps, reset 0. On write-clear coinciding with a drop, the count becomes 1.
- Undefined: 0x3C is unmapped and reads 0; only the sticky overflow bit exists.

Test Plan:
- Reset, then read 0x1C, 0x04, 0x00 -> 32'h0800_0000, 32'h0000_0001, 0. ts_irq=0 and all pulses 0.
- Write 0x10=16'h0001, 0x14=32'h1234_5678, 0x18=32'd500, then 0x00=32'h1 -> rtc_time_sec=48'h0001_1234_5678 and rtc_time_nsc=500 before pulse; rtc_time_ld high exactly 1 cycle, one cycle after the write.
- rtc_nsc_in counting, write 0x00=32'h4 -> 0x28 equals rtc_nsc_in value on the pulse cycle. Later reads are unchanged while the RTC keeps counting.
- Push 3 timestamps (info=1,2,3), then read 0x38 three times -> 1,2,3. STATUS level goes 3→0, ts_irq falls after the third read, and a fourth read returns 0.
- Push 9 without reads -> STATUS = full|overflow|level 8 (32'h0000_0806). Head info is the first pushed. Write 0x04=32'h4 clears overflow only.
- With the FIFO full, ts_valid coincident with a 0x38 read -> level stays 8, no overflow, and the new entry appears last. With LB_RTC_RGS_OVF_CNT_EN, the earlier 9th push leaves 0x3C=1.
